// File: rtl/wisc_pkg.sv
// Shared fetch-stage definitions: instruction width, HLT opcode, fetch FSM states.
package wisc_pkg;

    localparam int         INSTR_W = 16;
    localparam logic [3:0] OP_HLT  = 4'hF;

    typedef enum logic [1:0] {
        ISSUE,
        WAIT,
        HOLD,
        HALTED
    } fetch_state_t;

    // True when the word carries the halt opcode in its top nibble.
    function automatic logic is_hlt(input logic [INSTR_W-1:0] word);
        return word[INSTR_W-1 -: 4] == OP_HLT;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: instruction, fetch address + 2 and valid bit.
// Update priority is flush > stall > load > bubble.
module if_id_reg
    import wisc_pkg::*;
#(
    parameter logic [INSTR_W-1:0] NOP_INSTR = 16'h0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               stall,
    input  logic               load,
    input  logic [INSTR_W-1:0] load_instr,
    input  logic [15:0]        load_pc_plus2,
    output logic [INSTR_W-1:0] id_instr,
    output logic [15:0]        id_pc_plus2,
    output logic               id_valid
);

    // Flush bubbles, stall holds, otherwise take the new word or fall back to a bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            id_instr    <= NOP_INSTR;
            id_pc_plus2 <= '0;
            id_valid    <= 1'b0;
        end else if (flush) begin
            id_instr <= NOP_INSTR;
            id_valid <= 1'b0;
        end else if (!stall) begin
            if (load) begin
                id_instr    <= load_instr;
                id_pc_plus2 <= load_pc_plus2;
                id_valid    <= 1'b1;
            end else begin
                id_instr <= NOP_INSTR;
                id_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/if_id_stage.sv
// Fetch stage: one outstanding request to a multi-cycle instruction memory,
// one-entry skid buffer for responses that land while decode is stalled,
// and a drop flag so a branch flush discards the wrong-path word.
// Optional feature: define IF_ID_HALT_EN to stop fetching after an HLT is loaded.
module if_id_stage
    import wisc_pkg::*;
#(
    parameter logic [INSTR_W-1:0] NOP_INSTR = 16'h0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [15:0]        pc_addr,
    output logic               pc_stall,
    output logic               imem_req,
    output logic [15:0]        imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               imem_valid,
    input  logic               stall,
    input  logic               flush,
    output logic [INSTR_W-1:0] id_instr,
    output logic [15:0]        id_pc_plus2,
    output logic               id_valid,
    output logic               halt
);

    fetch_state_t       state, state_next;
    logic               run;        // low for the first cycle after reset so req starts a cycle late
    logic               drop;       // in-flight fetch is wrong-path
    logic [INSTR_W-1:0] skid_instr;
    logic [15:0]        skid_pc_plus2;
    logic               load;
    logic [INSTR_W-1:0] load_instr;
    logic [15:0]        load_pc_plus2;
    logic [15:0]        req_pc_plus2;

    assign req_pc_plus2 = imem_addr + 16'd2;   // wraps FFFE -> 0000

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ISSUE;
        else      state <= state_next;
    end

    // Next state, plus which word (fresh response or skid) goes into IF/ID.
    always_comb begin
        state_next    = state;
        load          = 1'b0;
        load_instr    = imem_rdata;
        load_pc_plus2 = req_pc_plus2;
        case (state)
            ISSUE: begin
                if (run) state_next = WAIT;
            end
            WAIT: begin
                if (imem_valid) begin
                    if (drop || flush) begin
                        state_next = ISSUE;
                    end else if (!stall) begin
                        load       = 1'b1;
                        state_next = ISSUE;
                    end else begin
                        state_next = HOLD;
                    end
                end
            end
            HOLD: begin
                load_instr    = skid_instr;
                load_pc_plus2 = skid_pc_plus2;
                if (flush) begin
                    state_next = ISSUE;
                end else if (!stall) begin
                    load       = 1'b1;
                    state_next = ISSUE;
                end
            end
            default: state_next = state;
        endcase
`ifdef IF_ID_HALT_EN
        if (load && is_hlt(load_instr)) state_next = HALTED;
`endif
    end

    // Outputs: request only from ISSUE; PC advances only on a consumed instruction.
    always_comb begin
        imem_req = (state == ISSUE) && run;
        pc_stall = !load;
    end

    // Request address, drop flag and skid buffer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run           <= 1'b0;
            imem_addr     <= '0;
            drop          <= 1'b0;
            skid_instr    <= NOP_INSTR;
            skid_pc_plus2 <= '0;
        end else begin
            run <= 1'b1;
            if (state == ISSUE && run) begin
                imem_addr <= pc_addr;
                drop      <= flush;
            end else if (state == WAIT && !imem_valid) begin
                drop <= drop | flush;
            end
            if (state == WAIT && imem_valid && !(drop || flush) && stall) begin
                skid_instr    <= imem_rdata;
                skid_pc_plus2 <= req_pc_plus2;
            end
        end
    end

`ifdef IF_ID_HALT_EN
    // Halt flag rises on the same edge the HLT word lands in IF/ID.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                               halt <= 1'b0;
        else if (load && is_hlt(load_instr))    halt <= 1'b1;
    end
`else
    assign halt = 1'b0;
`endif

    if_id_reg #(.NOP_INSTR(NOP_INSTR)) u_if_id_reg (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .stall         (stall),
        .load          (load),
        .load_instr    (load_instr),
        .load_pc_plus2 (load_pc_plus2),
        .id_instr      (id_instr),
        .id_pc_plus2   (id_pc_plus2),
        .id_valid      (id_valid)
    );

endmodule

// File: tb/tb_if_id_stage.sv
// Bench for if_id_stage: directed scenarios then randomized traffic, all checked
// against a transaction-level model (outstanding fetch, held word, IF/ID contents).
module tb_if_id_stage;

    logic        clk;
    logic        rst;
    logic [15:0] pc_addr;
    logic        pc_stall;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        imem_valid;
    logic        stall;
    logic        flush;
    logic [15:0] id_instr;
    logic [15:0] id_pc_plus2;
    logic        id_valid;
    logic        halt;

    int n_cmp = 0;
    int n_err = 0;

    // model state
    bit          out_v, out_taint, held_v, e_v, e_halt, halted, started;
    logic [15:0] out_addr, held_i, held_p, e_instr, e_pc2;
    int          out_cnt;

    if_id_stage dut (
        .clk         (clk),
        .rst         (rst),
        .pc_addr     (pc_addr),
        .pc_stall    (pc_stall),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_valid  (imem_valid),
        .stall       (stall),
        .flush       (flush),
        .id_instr    (id_instr),
        .id_pc_plus2 (id_pc_plus2),
        .id_valid    (id_valid),
        .halt        (halt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        out_v = 0; out_taint = 0; held_v = 0; out_cnt = 0;
        e_v = 0; e_instr = 16'h0000; e_pc2 = 16'h0000;
        e_halt = 0; halted = 0; started = 0;
    endtask

    // Assert reset for two cycles, check reset values, release after a posedge.
    task automatic do_reset();
        rst = 0; stall = 0; flush = 0; imem_valid = 0; imem_rdata = 0; pc_addr = 0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_imem_req", imem_req, 1'b0);
        chk("rst_pc_stall", pc_stall, 1'b1);
        chk("rst_id_valid", id_valid, 1'b0);
        chk("rst_id_instr", id_instr, 16'h0000);
        chk("rst_id_pc_plus2", id_pc_plus2, 16'h0000);
        chk("rst_imem_addr", imem_addr, 16'h0000);
        chk("rst_halt", halt, 1'b0);
        rst = 1;
    endtask

    // One clock cycle, entered and left at posedge+1.
    task automatic step(input logic st, input logic fl, input logic [15:0] pc,
                        input logic [15:0] rd, input int lat);
        bit          arriving, ld, exp_req;
        logic [15:0] ldi, ldp;
        ld = 0; ldi = 0; ldp = 0;
        // registered outputs from the previous edge
        chk("id_valid", id_valid, e_v);
        if (e_v) begin
            chk("id_instr", id_instr, e_instr);
            chk("id_pc_plus2", id_pc_plus2, e_pc2);
        end else begin
            chk("id_instr_nop", id_instr, 16'h0000);
        end
        chk("halt", halt, e_halt);
        if (out_v) chk("imem_addr", imem_addr, out_addr);
        // drive this cycle
        arriving   = out_v && (out_cnt == 0);
        stall      = st;
        flush      = fl;
        pc_addr    = pc;
        imem_valid = arriving;
        imem_rdata = arriving ? rd : 16'($urandom);
        #1;
        exp_req = started && !halted && !out_v && !held_v;
        chk("imem_req", imem_req, exp_req);
        if (exp_req) begin
            out_v = 1; out_addr = pc; out_taint = fl; out_cnt = lat;
        end
        if (arriving) begin
            out_v = 0;
            if (!(out_taint || fl)) begin
                if (!st) begin
                    ld = 1; ldi = rd; ldp = 16'(out_addr + 16'd2);
                end else begin
                    held_v = 1; held_i = rd; held_p = 16'(out_addr + 16'd2);
                end
            end
        end else if (held_v) begin
            if (fl) held_v = 0;
            else if (!st) begin
                ld = 1; ldi = held_i; ldp = held_p; held_v = 0;
            end
        end else if (out_v && fl) begin
            out_taint = 1;
        end
        chk("pc_stall", pc_stall, !ld);
        if (fl) e_v = 0;
        else if (!st) begin
            if (ld) begin e_v = 1; e_instr = ldi; e_pc2 = ldp; end
            else e_v = 0;
        end
        if (!e_v) e_instr = 16'h0000;
`ifdef IF_ID_HALT_EN
        if (ld && ldi[15:12] == 4'hF) begin halted = 1; e_halt = 1; end
`endif
        if (out_v && out_cnt > 0) out_cnt--;
        started = 1;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] rnd_word();
        logic [3:0] op;
        op = 4'($urandom_range(0, 14));
        return {op, 12'($urandom)};
    endfunction

    initial begin
        clk = 0;
        do_reset();

        // first cycle after release: no request yet; then request at pc 0000
        step(0, 0, 16'h0000, 16'hA123, 1);
        step(0, 0, 16'h0000, 16'hA123, 1);
        chk("t1_imem_addr", imem_addr, 16'h0000);
        step(0, 0, 16'h0000, 16'hA123, 1);
        chk("t2_id_instr", id_instr, 16'hA123);
        chk("t2_id_pc_plus2", id_pc_plus2, 16'h0002);
        chk("t2_id_valid", id_valid, 1'b1);

        // stall across the response: word waits in the skid buffer
        step(1, 0, 16'h0002, 16'h1234, 1);
        step(1, 0, 16'h0002, 16'h1234, 1);
        step(1, 0, 16'h0002, 16'h1234, 1);
        chk("t3_held_instr", id_instr, 16'hA123);
        step(0, 0, 16'h0002, 16'h1234, 1);
        chk("t3_id_instr", id_instr, 16'h1234);
        chk("t3_id_pc_plus2", id_pc_plus2, 16'h0004);

        // flush while the fetch is in flight: response discarded
        step(0, 0, 16'h0004, 16'h5555, 2);
        step(0, 1, 16'h0004, 16'h5555, 2);
        chk("t4_id_valid", id_valid, 1'b0);
        step(0, 0, 16'h0040, 16'h5555, 1);
        step(0, 0, 16'h0040, 16'h7777, 1);
        chk("t4_imem_addr", imem_addr, 16'h0040);
        step(0, 0, 16'h0042, 16'h7777, 1);
        chk("t4_id_instr", id_instr, 16'h7777);

        // wraparound of pc + 2
        step(0, 0, 16'hFFFE, 16'h0ABC, 1);
        step(0, 0, 16'hFFFE, 16'h0ABC, 1);
        chk("t5_id_pc_plus2", id_pc_plus2, 16'h0000);

        // randomized traffic with a reset in the middle
        for (int i = 0; i < 400; i++) begin
            if (i == 200) do_reset();
            step(($urandom % 4) == 0, ($urandom % 8) == 0,
                 16'($urandom) & 16'hFFFE, rnd_word(), int'($urandom_range(1, 3)));
        end

        // HLT word
        do_reset();
        step(0, 0, 16'h0100, 16'hF000, 1);
        step(0, 0, 16'h0100, 16'hF000, 1);
        step(0, 0, 16'h0100, 16'hF000, 1);
        for (int i = 0; i < 10; i++) step(0, 0, 16'h0102, 16'h0123, 1);
`ifdef IF_ID_HALT_EN
        chk("t6_halt", halt, 1'b1);
`else
        chk("t6_halt", halt, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
